// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer logic.
//   bin2gray / gray2bin : pointer code conversion, also used by the write-side full logic.
//                         Both operate on a PTR_MAX-bit word; callers zero-extend narrower
//                         pointers and size-cast the result back.
//   ADDRSIZE_DEF        : default RAM address width.
//   DATASIZE_DEF        : default data width.
package fifo_pkg;

    localparam int unsigned ADDRSIZE_DEF = 4;
    localparam int unsigned DATASIZE_DEF = 32;
    localparam int unsigned PTR_MAX      = 32;

    typedef logic [PTR_MAX-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return (b >> 1) ^ b;
    endfunction

    // Zero-extended Gray codes convert correctly: the leading zeros stay zero.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry head/skid output buffer for the first-word-fall-through read port.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears both entries
//   push   : a word arrives on din this cycle
//   din    : arriving word
//   pop    : head is consumed this cycle (only asserted while valid)
//   occ    : number of occupied entries, 0..2
//   dout   : head word
//   valid  : head word is valid
// The caller guarantees no push while full unless a pop happens in the same cycle.
module fifo_out_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = DATASIZE_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push,
    input  logic [DATASIZE-1:0] din,
    input  logic                pop,
    output logic [1:0]          occ,
    output logic [DATASIZE-1:0] dout,
    output logic                valid
);

    logic [DATASIZE-1:0] head_q, head_d;
    logic [DATASIZE-1:0] skid_q, skid_d;
    logic [1:0]          occ_q, occ_d;

    always_comb begin
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        head_d = head_q;
        skid_d = skid_q;

        // Popping with both entries full: the skid word becomes the new head.
        if (pop && (occ_q == 2'd2)) begin
            head_d = skid_q;
        end

        if (push) begin
            // Head is free (or freed this cycle with nothing waiting behind it).
            if ((occ_q == 2'd0) || (pop && (occ_q == 2'd1))) begin
                head_d = din;
            end else begin
                skid_d = din;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            skid_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            occ_q  <= occ_d;
        end
    end

    assign occ   = occ_q;
    assign dout  = head_q;
    assign valid = (occ_q != 2'd0);

endmodule

// File: rtl/fifo_rptr_empty_fwft.sv
// Read-side control of the async FIFO with a first-word-fall-through AXI-Stream output.
//   rclk     : read-domain clock
//   rrst     : synchronous active-high reset
//   rq2_wptr : Gray write pointer, already synchronized into the read domain
//   rptr     : registered Gray read pointer, to the read-to-write synchronizer
//   raddr    : RAM read address (low bits of the binary read pointer)
//   rden     : RAM read enable; rdata is valid one cycle later
//   rdata    : RAM read data
//   m_tdata  : head word
//   m_tvalid : head word valid
//   m_tready : downstream accept
//   rempty   : registered flag, RAM holds no unread word (buffer may still hold words)
//   rlevel   : registered count of RAM words not yet read
module fifo_rptr_empty_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
    parameter int unsigned DATASIZE = DATASIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rden,
    input  logic [DATASIZE-1:0] rdata,
    output logic [DATASIZE-1:0] m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin_q, rbinnext;
    logic [PW-1:0] rptr_q, rgraynext;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          pend_q;
    logic [1:0]    occ;
    logic          pop;
    logic [2:0]    committed;

    always_comb begin
        pop = m_tvalid & m_tready;
        // Entries that will be occupied next cycle before any new read lands.
        committed = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
        rden      = !rempty_q && (committed <= 3'd1);
        rbinnext  = rbin_q + {{ADDRSIZE{1'b0}}, rden};
        rgraynext = PW'(bin2gray(ptr_word_t'(rbinnext)));
        rempty_d  = (rgraynext == rq2_wptr);
        rlevel_d  = PW'(gray2bin(ptr_word_t'(rq2_wptr))) - rbinnext;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rlevel_q <= '0;
            rempty_q <= 1'b1;
            pend_q   <= 1'b0;
        end else begin
            rbin_q   <= rbinnext;
            rptr_q   <= rgraynext;
            rlevel_q <= rlevel_d;
            rempty_q <= rempty_d;
            pend_q   <= rden;
        end
    end

    // Clearing pend_q on reset keeps the read that was in flight from being captured.
    fifo_out_skid #(
        .DATASIZE(DATASIZE)
    ) u_skid (
        .clk_i (rclk),
        .rst_i (rrst),
        .push  (pend_q),
        .din   (rdata),
        .pop   (pop),
        .occ   (occ),
        .dout  (m_tdata),
        .valid (m_tvalid)
    );

    assign rptr   = rptr_q;
    assign raddr  = rbin_q[ADDRSIZE-1:0];
    assign rempty = rempty_q;
    assign rlevel = rlevel_q;

endmodule
